// File: rtl/memory_access_pkg.sv
// ----------------------------------------------------------------------------
// memory_access_pkg : shared MEM-stage types and constants        (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package memory_access_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int C_DEFAULT_TIMEOUT = 16;
  localparam int C_REG_W           = 5;
  localparam int C_CTRL_W          = 7;

  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_flopenr.sv
// ----------------------------------------------------------------------------
// flopenr : resettable, enabled, width-parameterised register     (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ----------------------------------------------------------------------------
// memory_access : MEM stage - EX/MEM, MEM/WB and data-memory FSM  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module memory_access
  import memory_access_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = C_DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               MemRead_E,
  input  logic               MemWrite_E,
  input  logic               RegWrite_E,
  input  logic               MemtoReg_E,
  input  logic               Branch_E,
  input  logic [N-1:0]       aluResult_E,
  input  logic [N-1:0]       writeData_E,
  input  logic [N-1:0]       PCBranch_E,
  input  logic               zero_E,
  input  logic [C_REG_W-1:0] RegRd_E,
  output logic               dm_req,
  output logic               dm_we,
  output logic [N-1:0]       dm_addr,
  output logic [N-1:0]       dm_wdata,
  input  logic               dm_ack,
  input  logic [N-1:0]       dm_rdata,
  output logic               stall,
  output logic [N-1:0]       EX_MEMResult,
  output logic [C_REG_W-1:0] EX_MEMRegRd,
  output logic               EX_MEMregWrite,
  output logic               PCSrc,
  output logic [N-1:0]       PCBranch_M,
  output logic [N-1:0]       memoryResult,
  output logic [C_REG_W-1:0] MEM_WBRegRd,
  output logic               MEM_WBregWrite,
  output logic               mem_err
);

  localparam int               CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int               EXMEM_W    = C_CTRL_W + C_REG_W + 3 * N;
  localparam int               MEMWB_W    = 1 + C_REG_W + N;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_err;

  logic               w_in_wait;
  logic               w_timeout;
  logic               w_done;
  logic               w_stall;
  logic [N-1:0]       w_rdata;

  logic [EXMEM_W-1:0] w_exmem_d;
  logic [EXMEM_W-1:0] w_exmem_q;
  logic [MEMWB_W-1:0] w_memwb_d;
  logic [MEMWB_W-1:0] w_memwb_q;

  logic               w_valid_M;
  logic               w_memread_M;
  logic               w_memwrite_M;
  logic               w_regwrite_M;
  logic               w_memtoreg_M;
  logic               w_branch_M;
  logic               w_zero_M;
  logic [C_REG_W-1:0] w_regrd_M;
  logic [N-1:0]       w_alu_M;
  logic [N-1:0]       w_wdata_M;
  logic [N-1:0]       w_pcb_M;
  logic               w_memop_M;

  assign w_exmem_d = {ex_valid, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, Branch_E,
                      zero_E, RegRd_E, aluResult_E, writeData_E, PCBranch_E};

  flopenr #(.WIDTH(EXMEM_W)) u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .i_en  (!w_stall),
    .i_d   (w_exmem_d),
    .o_q   (w_exmem_q)
  );

  assign {w_valid_M, w_memread_M, w_memwrite_M, w_regwrite_M, w_memtoreg_M, w_branch_M,
          w_zero_M, w_regrd_M, w_alu_M, w_wdata_M, w_pcb_M} = w_exmem_q;

  assign w_memop_M = is_mem_op(w_valid_M, w_memread_M, w_memwrite_M);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_stall ? (r_cnt + CNT_W'(1)) : '0;
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Gating with reset keeps the memory port, stall and branch quiet while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_in_wait    = 1'b0;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    w_stall      = 1'b0;
    w_rdata      = '0;
    if (reset && (r_state == WAIT) && w_memop_M) begin
      w_in_wait = 1'b1;
      w_timeout = !dm_ack && (r_cnt == C_CNT_LAST);
      w_done    = dm_ack || w_timeout;
      w_stall   = !w_done;
      if (dm_ack) begin
        w_rdata = dm_rdata;
      end
    end
    if (!w_stall) begin
      w_state_next = is_mem_op(ex_valid, MemRead_E, MemWrite_E) ? WAIT : IDLE;
    end
  end

  assign w_memwb_d = w_stall ? {MEMWB_W{1'b0}}
                             : {w_valid_M & w_regwrite_M, w_regrd_M,
                                (w_memtoreg_M ? w_rdata : w_alu_M)};

  flopenr #(.WIDTH(MEMWB_W)) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .i_en  (1'b1),
    .i_d   (w_memwb_d),
    .o_q   (w_memwb_q)
  );

  assign {MEM_WBregWrite, MEM_WBRegRd, memoryResult} = w_memwb_q;

  assign dm_req         = w_in_wait;
  assign dm_we          = w_in_wait & w_memwrite_M;
  assign dm_addr        = w_in_wait ? w_alu_M : '0;
  assign dm_wdata       = w_in_wait ? w_wdata_M : '0;
  assign stall          = w_stall;
  assign EX_MEMResult   = w_alu_M;
  assign EX_MEMRegRd    = w_regrd_M;
  assign EX_MEMregWrite = w_valid_M & w_regwrite_M;
  assign PCSrc          = reset & w_valid_M & w_branch_M & w_zero_M;
  assign PCBranch_M     = w_pcb_M;
  assign mem_err        = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ----------------------------------------------------------------------------
// tb_memory_access : directed scoreboard bench for memory_access  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E, Branch_E, zero_E;
  logic [63:0] aluResult_E, writeData_E, PCBranch_E;
  logic [4:0]  RegRd_E;
  logic        dm_req, dm_we, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall, EX_MEMregWrite, PCSrc, MEM_WBregWrite, mem_err;
  logic [63:0] EX_MEMResult, PCBranch_M, memoryResult;
  logic [4:0]  EX_MEMRegRd, MEM_WBRegRd;

  memory_access dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E),
    .MemtoReg_E(MemtoReg_E), .Branch_E(Branch_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .RegRd_E(RegRd_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .EX_MEMResult(EX_MEMResult), .EX_MEMRegRd(EX_MEMRegRd), .EX_MEMregWrite(EX_MEMregWrite),
    .PCSrc(PCSrc), .PCBranch_M(PCBranch_M), .memoryResult(memoryResult),
    .MEM_WBRegRd(MEM_WBRegRd), .MEM_WBregWrite(MEM_WBregWrite), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  logic [68:0]  wb_q[$];
  logic [128:0] dm_q[$];

  int   ack_delay = 0;
  logic force_ack = 1'b0;
  int   rsp_cnt = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    return (a == 64'h40) ? 64'hDEAD : a + 64'h1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ack after ack_delay wait cycles (-1 = never).
  always @(negedge clk) begin
    prev_req = dm_req;
    prev_ack = dm_ack;
  end

  always @(posedge clk) begin
    #1;
    if (dm_req && prev_req && !prev_ack) rsp_cnt++;
    else rsp_cnt = 0;
    dm_rdata = mem_model(dm_addr);
    dm_ack   = force_ack || (dm_req && (ack_delay >= 0) && (rsp_cnt >= ack_delay));
  end

  // Monitor: pops expectations whenever the DUT presents a writeback or a memory handshake.
  always @(negedge clk) begin
    logic [68:0]  ew;
    logic [128:0] ed;
    if (stall === 1'b1) stall_cnt++;
    if (dm_req === 1'b1) req_cnt++;
    if (MEM_WBregWrite === 1'b1) begin
      n_vec++;
      if (wb_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no writeback", MEM_WBRegRd, memoryResult);
      end else begin
        ew = wb_q.pop_front();
        if ({MEM_WBRegRd, memoryResult} !== ew) begin
          n_err++;
          $display("FAIL wb: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                   MEM_WBRegRd, memoryResult, ew[68:64], ew[63:0]);
        end
      end
    end
    if (dm_req === 1'b1 && dm_ack === 1'b1) begin
      n_vec++;
      if (dm_q.size() == 0) begin
        n_err++;
        $display("FAIL dm_unexpected: got we=%0b addr=0x%0h, expected no access", dm_we, dm_addr);
      end else begin
        ed = dm_q.pop_front();
        if ({dm_we, dm_addr, dm_wdata} !== ed) begin
          n_err++;
          $display("FAIL dm: got we=%0b addr=0x%0h wdata=0x%0h, expected we=%0b addr=0x%0h wdata=0x%0h",
                   dm_we, dm_addr, dm_wdata, ed[128], ed[127:64], ed[63:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_bubble();
    ex_valid = 0; MemRead_E = 0; MemWrite_E = 0; RegWrite_E = 0; MemtoReg_E = 0;
    Branch_E = 0; zero_E = 0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0; RegRd_E = '0;
  endtask

  // Presents an instruction and holds it until EX/MEM accepts it.
  task automatic send(input logic v, input logic rd, input logic wr, input logic rw,
                      input logic m2r, input logic br, input logic z,
                      input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pcb,
                      input logic [4:0] dst);
    logic captured;
    int   guard;
    ex_valid = v; MemRead_E = rd; MemWrite_E = wr; RegWrite_E = rw; MemtoReg_E = m2r;
    Branch_E = br; zero_E = z; aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb; RegRd_E = dst;
    captured = 1'b0;
    guard = 0;
    while (!captured) begin
      @(negedge clk);
      captured = (stall === 1'b0);
      @(posedge clk);
      #1;
      guard++;
      if (!captured && guard > 100) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: got stall=1 for %0d cycles, expected capture", guard);
        captured = 1'b1;
      end
    end
    set_bubble();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    set_bubble();
    dm_ack = 0; dm_rdata = '0;
    reset = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_pcsrc", {63'd0, PCSrc}, 64'd0);
    check("rst_dm_req", {63'd0, dm_req}, 64'd0);
    check("rst_exmem", EX_MEMResult, 64'd0);
    check("rst_memwb", memoryResult, 64'd0);
    check("rst_mem_err", {63'd0, mem_err}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1);

    // ALU op X1 = 5
    stall_cnt = 0;
    wb_q.push_back({5'd1, 64'd5});
    send(1, 0, 0, 1, 0, 0, 0, 64'd5, 64'd0, 64'd0, 5'd1);
    check("alu_exmem_result", EX_MEMResult, 64'd5);
    check("alu_exmem_regwrite", {63'd0, EX_MEMregWrite}, 64'd1);
    check("alu_exmem_rd", {59'd0, EX_MEMRegRd}, 64'd1);
    step(1);
    check("alu_memwb_result", memoryResult, 64'd5);
    check("alu_memwb_rd", {59'd0, MEM_WBRegRd}, 64'd1);
    step(1);
    check("alu_stall_cnt", 64'(stall_cnt), 64'd0);

    // Branch taken / not taken
    send(1, 0, 0, 0, 0, 1, 1, 64'd0, 64'd0, 64'h100, 5'd0);
    check("br_taken_pcsrc", {63'd0, PCSrc}, 64'd1);
    check("br_target", PCBranch_M, 64'h100);
    send(1, 0, 0, 0, 0, 1, 0, 64'd0, 64'd0, 64'h200, 5'd0);
    check("br_not_taken_pcsrc", {63'd0, PCSrc}, 64'd0);

    // Invalid slot carrying mem/regwrite bits is ignored
    send(0, 1, 0, 1, 1, 0, 0, 64'h99, 64'd0, 64'd0, 5'd9);
    check("bubble_regwrite", {63'd0, EX_MEMregWrite}, 64'd0);
    check("bubble_dm_req", {63'd0, dm_req}, 64'd0);
    step(1);

    // LDUR 0x40 with three wait cycles
    ack_delay = 3;
    stall_cnt = 0;
    wb_q.push_back({5'd2, 64'hDEAD});
    dm_q.push_back({1'b0, 64'h40, 64'h55});
    send(1, 1, 0, 1, 1, 0, 0, 64'h40, 64'h55, 64'd0, 5'd2);
    guard = 0;
    @(negedge clk);
    while (!(dm_req === 1'b1 && dm_ack === 1'b1) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("ld_ack_seen", {63'd0, guard < 30}, 64'd1);
    @(posedge clk); #1;
    check("ld_memwb_result", memoryResult, 64'hDEAD);
    check("ld_memwb_regwrite", {63'd0, MEM_WBregWrite}, 64'd1);
    step(2);
    check("ld_stall_cnt", 64'(stall_cnt), 64'd3);

    // STUR 0x80 <- 7, ack tied high
    ack_delay = 0;
    stall_cnt = 0;
    req_cnt = 0;
    dm_q.push_back({1'b1, 64'h80, 64'h7});
    send(1, 0, 1, 0, 0, 0, 0, 64'h80, 64'h7, 64'd0, 5'd0);
    step(3);
    check("st_stall_cnt", 64'(stall_cnt), 64'd0);
    check("st_req_cnt", 64'(req_cnt), 64'd1);

    // Back-to-back zero-wait LDURs
    stall_cnt = 0;
    req_cnt = 0;
    wb_q.push_back({5'd3, 64'h11});
    wb_q.push_back({5'd4, 64'h19});
    dm_q.push_back({1'b0, 64'h10, 64'h0});
    dm_q.push_back({1'b0, 64'h18, 64'h0});
    send(1, 1, 0, 1, 1, 0, 0, 64'h10, 64'h0, 64'd0, 5'd3);
    send(1, 1, 0, 1, 1, 0, 0, 64'h18, 64'h0, 64'd0, 5'd4);
    step(3);
    check("b2b_req_cnt", 64'(req_cnt), 64'd2);
    check("b2b_stall_cnt", 64'(stall_cnt), 64'd0);

    // Timeout: ack never arrives
    ack_delay = -1;
    stall_cnt = 0;
    wb_q.push_back({5'd5, 64'd0});
    send(1, 1, 0, 1, 1, 0, 0, 64'h200, 64'h0, 64'd0, 5'd5);
    check("to_mem_err_early", {63'd0, mem_err}, 64'd0);
    step(20);
    check("to_stall_cnt", 64'(stall_cnt), 64'd15);
    check("to_mem_err", {63'd0, mem_err}, 64'd1);
    step(3);
    check("to_mem_err_sticky", {63'd0, mem_err}, 64'd1);

    // Reset in the middle of a WAIT, ack arriving afterwards
    send(1, 1, 0, 1, 1, 0, 0, 64'h300, 64'h0, 64'd0, 5'd6);
    step(2);
    check("rw_waiting", {63'd0, stall}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rw_in_rst_req", {63'd0, dm_req}, 64'd0);
    check("rw_in_rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    step(1);
    reset = 1'b1;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_dm_req", {63'd0, dm_req}, 64'd0);
      check("rw_stall", {63'd0, stall}, 64'd0);
      check("rw_mem_err", {63'd0, mem_err}, 64'd0);
      check("rw_memwb", memoryResult, 64'd0);
      check("rw_dm_addr", dm_addr, 64'd0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    step(1);

    // Normal operation after reset
    ack_delay = 0;
    wb_q.push_back({5'd31, 64'hABCD});
    send(1, 0, 0, 1, 0, 0, 0, 64'hABCD, 64'd0, 64'd0, 5'd31);
    step(3);

    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("dm_queue_drained", 64'(dm_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
